frame_buffer_reader: RTL and testbench
======================================

# frame_buffer_reader

Read-side scanner for the 320x240 pixel frame buffer. On a start pulse it walks the buffer in raster order, issues reads to the single-port synchronous RAM (1-cycle read latency), and streams pixels with their x/y coordinates over a valid/ready interface toward the display/processing path. It is the counterpart of the write-side coordinate counter: same raster order, same address mapping (addr = y*X_COUNT + x), same wrap at end of frame.

## Interface
- X_COUNT, 320, pixels per line
- Y_COUNT, 240, lines per frame
- X_WIDTH, 9, width of x coordinate
- Y_WIDTH, 8, width of y coordinate
- ADDR_WIDTH, 17, buffer address width (must hold X_COUNT*Y_COUNT-1)
- DATA_WIDTH, 16, pixel width
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin one frame read; sampled only in IDLE
- busy  out  1  high from accepted start until frame_done
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_WIDTH  RAM read address
- rd_data  in  DATA_WIDTH  RAM data, valid the cycle after rd_en
- pix_data  out  DATA_WIDTH  pixel value
- pix_x  out  X_WIDTH  pixel column
- pix_y  out  Y_WIDTH  pixel row
- pix_sof  out  1  first pixel of frame (x=0,y=0)
- pix_eol  out  1  last pixel of line (x=X_COUNT-1)
- pix_eof  out  1  last pixel of frame
- pix_valid  out  1  output beat valid
- pix_ready  in  1  sink accepts beat
- frame_done  out  1  one-cycle pulse after final beat accepted

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: start=1 -> READ; read counter (rd_x, rd_y, rd_addr) cleared to 0; busy=1.
- READ: rd_en = 1 when (fifo_count + inflight - pop) < 2, where pop = pix_valid & pix_ready this cycle. Each rd_en advances the read counter: x+1; at x=X_COUNT-1, x->0 and y+1. rd_en at the last address (X_COUNT*Y_COUNT-1) -> DRAIN.
- inflight: 1-bit register, = rd_en of previous cycle. Returning rd_data is pushed into a 2-entry output FIFO together with its x, y, sof, eol, eof tags (carried from issue time).
- DRAIN: no reads; leaves when FIFO empty, inflight=0, and the eof beat has been accepted -> IDLE, frame_done pulses 1 cycle, busy drops in the same cycle.
- Credit rule guarantees FIFO never overflows; no beat dropped or duplicated under any pix_ready pattern.
- Output beat: pix_* and tags held stable while pix_valid=1 and pix_ready=0.
- start while busy ignored (no restart, no queueing).
- Reset (any state, mid-frame): all state cleared, FIFO flushed, in-flight return discarded.
- Reset values: busy=0, rd_en=0, rd_addr=0, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, pix_sof=0, pix_eol=0, pix_eof=0, frame_done=0.

## Timing
- start sampled at edge T0 -> rd_en=1, rd_addr=0 in cycle after T0 -> data pushed at T2 -> pix_valid=1 from T2.
- With pix_ready held 1: one beat per cycle, X_COUNT*Y_COUNT consecutive beats, no bubbles.
- Under backpressure: at most 2 reads outstanding beyond accepted beats.
- frame_done asserted the cycle after the eof handshake edge; new start accepted from that IDLE cycle on.
- rd_addr wraps to 0 only through IDLE/start; never increments past the last address.

## Structure
- Package fb_pkg: X_COUNT/Y_COUNT/width defaults, FRAME_SIZE constant, state enum (IDLE, READ, DRAIN), pixel beat struct (data, x, y, sof, eol, eof).
- Sub-module pix_fifo2: 2-entry FIFO of beat structs, push/pop/count/empty/full, async active-low reset.
- Top holds FSM, read counter, inflight register, credit logic.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately, busy=0.
- Full frame, pix_ready=1, RAM model data=addr: first pix_valid 2 cycles after start; 76800 back-to-back beats; beat 0 sof x=0 y=0; beat 319 eol x=319 y=0; beat 320 x=0 y=1 data=320; beat 76799 eof x=319 y=239; frame_done next cycle, busy=0.
- Backpressure: pix_ready=0 for 10 cycles at beat 5 -> beat 5 held stable, rd_addr stops at 7, resumes in order, no loss/duplicate.
- start pulsed at beat 100 while busy -> ignored, frame completes normally with 76800 beats.
- Reset at beat 1000 then start -> stream restarts at addr 0, sof, x=0 y=0.
- X_COUNT=4, Y_COUNT=3, random pix_ready: 12 beats, data 0..11 in order, eol on 3/7/11, eof on 11 only.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the frame buffer read path: default geometry,
// scanner states and the pixel beat carried through the output FIFO.
package fb_pkg;

    localparam int FB_X_COUNT    = 320;
    localparam int FB_Y_COUNT    = 240;
    localparam int FB_X_WIDTH    = 9;
    localparam int FB_Y_WIDTH    = 8;
    localparam int FB_ADDR_WIDTH = 17;
    localparam int FB_DATA_WIDTH = 16;
    localparam int FB_FRAME_SIZE = FB_X_COUNT * FB_Y_COUNT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } fb_state_t;

    typedef struct packed {
        logic [FB_DATA_WIDTH-1:0] data;
        logic [FB_X_WIDTH-1:0]    x;
        logic [FB_Y_WIDTH-1:0]    y;
        logic                     sof;
        logic                     eol;
        logic                     eof;
    } pix_beat_t;

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry FIFO of pixel beats; the head entry drives the output stream
// directly so a stalled beat stays stable until it is popped.
module pix_fifo2
    import fb_pkg::*;
#(
    parameter type T = pix_beat_t
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  T           i_data,
    input  logic       i_pop,
    output T           o_head,
    output logic [1:0] o_count,
    output logic       o_empty,
    output logic       o_full
);

    T           r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_pop  = i_pop & (r_count != 2'd0);
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == 2'd0);
    assign o_full  = (r_count == 2'd2);

endmodule

// File: rtl/frame_buffer_reader.sv
// Raster-order frame buffer scanner: issues RAM reads under a two-beat credit
// limit and streams the returned pixels with coordinates over valid/ready.
module frame_buffer_reader
    import fb_pkg::*;
#(
    parameter int X_COUNT    = FB_X_COUNT,
    parameter int Y_COUNT    = FB_Y_COUNT,
    parameter int X_WIDTH    = FB_X_WIDTH,
    parameter int Y_WIDTH    = FB_Y_WIDTH,
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int DATA_WIDTH = FB_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [DATA_WIDTH-1:0] o_pix_data,
    output logic [X_WIDTH-1:0]    o_pix_x,
    output logic [Y_WIDTH-1:0]    o_pix_y,
    output logic                  o_pix_sof,
    output logic                  o_pix_eol,
    output logic                  o_pix_eof,
    output logic                  o_pix_valid,
    input  logic                  i_pix_ready,
    output logic                  o_frame_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(X_COUNT * Y_COUNT - 1);
    localparam logic [X_WIDTH-1:0]    LAST_X    = X_WIDTH'(X_COUNT - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [X_WIDTH-1:0]    x;
        logic [Y_WIDTH-1:0]    y;
        logic                  sof;
        logic                  eol;
        logic                  eof;
    } beat_t;

    fb_state_t             r_state;
    logic                  r_busy;
    logic                  r_frame_done;
    logic [X_WIDTH-1:0]    r_rd_x;
    logic [Y_WIDTH-1:0]    r_rd_y;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_inflight;
    logic [X_WIDTH-1:0]    r_tag_x;
    logic [Y_WIDTH-1:0]    r_tag_y;
    logic                  r_tag_sof;
    logic                  r_tag_eol;
    logic                  r_tag_eof;

    beat_t                 w_push_beat;
    beat_t                 w_head;
    logic [1:0]            w_count;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [2:0]            w_credit;
    logic                  w_rd_en;

    // Beats already buffered plus the one in flight, minus the one leaving now.
    assign w_pop    = ~w_empty & i_pix_ready;
    assign w_credit = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en  = (r_state == READ) && (w_credit < 3'd2);
    assign w_push   = r_inflight & (~w_full | w_pop);

    assign w_push_beat = '{data: i_rd_data, x: r_tag_x, y: r_tag_y,
                           sof: r_tag_sof, eol: r_tag_eol, eof: r_tag_eof};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_rd_x       <= '0;
            r_rd_y       <= '0;
            r_rd_addr    <= '0;
            r_inflight   <= 1'b0;
            r_tag_x      <= '0;
            r_tag_y      <= '0;
            r_tag_sof    <= 1'b0;
            r_tag_eol    <= 1'b0;
            r_tag_eof    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_inflight   <= w_rd_en;
            if (w_rd_en) begin
                r_tag_x   <= r_rd_x;
                r_tag_y   <= r_rd_y;
                r_tag_sof <= (r_rd_addr == '0);
                r_tag_eol <= (r_rd_x == LAST_X);
                r_tag_eof <= (r_rd_addr == LAST_ADDR);
            end
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state   <= READ;
                        r_busy    <= 1'b1;
                        r_rd_x    <= '0;
                        r_rd_y    <= '0;
                        r_rd_addr <= '0;
                    end
                end
                READ: begin
                    // The counter parks on the last address; only a new start rewinds it.
                    if (w_rd_en) begin
                        if (r_rd_addr == LAST_ADDR) begin
                            r_state <= DRAIN;
                        end else begin
                            r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                            if (r_rd_x == LAST_X) begin
                                r_rd_x <= '0;
                                r_rd_y <= r_rd_y + Y_WIDTH'(1);
                            end else begin
                                r_rd_x <= r_rd_x + X_WIDTH'(1);
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && w_head.eof) begin
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    pix_fifo2 #(
        .T (beat_t)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (w_push_beat),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign o_busy       = r_busy;
    assign o_rd_en      = w_rd_en;
    assign o_rd_addr    = r_rd_addr;
    assign o_pix_data   = w_head.data;
    assign o_pix_x      = w_head.x;
    assign o_pix_y      = w_head.y;
    assign o_pix_sof    = w_head.sof;
    assign o_pix_eol    = w_head.eol;
    assign o_pix_eof    = w_head.eof;
    assign o_pix_valid  = ~w_empty;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench for frame_buffer_reader on a 4x3 frame with a RAM model
// that returns each address as its data.
module tb_frame_buffer_reader;

    localparam int XC    = 4;
    localparam int YC    = 3;
    localparam int FRAME = XC * YC;
    localparam int AW    = 17;
    localparam int DW    = 16;
    localparam int XW    = 9;
    localparam int YW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] pix_data;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          pix_sof;
    logic          pix_eol;
    logic          pix_eof;
    logic          pix_valid;
    logic          pix_ready;
    logic          frame_done;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    // Synchronous RAM with one cycle of read latency; content equals address.
    always @(posedge clk) begin
        if (rd_en) rd_data <= DW'(rd_addr);
    end

    frame_buffer_reader #(
        .X_COUNT    (XC),
        .Y_COUNT    (YC),
        .X_WIDTH    (XW),
        .Y_WIDTH    (YW),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .o_busy       (busy),
        .o_rd_en      (rd_en),
        .o_rd_addr    (rd_addr),
        .i_rd_data    (rd_data),
        .o_pix_data   (pix_data),
        .o_pix_x      (pix_x),
        .o_pix_y      (pix_y),
        .o_pix_sof    (pix_sof),
        .o_pix_eol    (pix_eol),
        .o_pix_eof    (pix_eof),
        .o_pix_valid  (pix_valid),
        .i_pix_ready  (pix_ready),
        .o_frame_done (frame_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r);
        start     = s;
        pix_ready = r;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"},       32'(busy),       0);
        checkOutput({tag, "_rd_en"},      32'(rd_en),      0);
        checkOutput({tag, "_rd_addr"},    32'(rd_addr),    0);
        checkOutput({tag, "_valid"},      32'(pix_valid),  0);
        checkOutput({tag, "_data"},       32'(pix_data),   0);
        checkOutput({tag, "_x"},          32'(pix_x),      0);
        checkOutput({tag, "_y"},          32'(pix_y),      0);
        checkOutput({tag, "_sof"},        32'(pix_sof),    0);
        checkOutput({tag, "_eol"},        32'(pix_eol),    0);
        checkOutput({tag, "_eof"},        32'(pix_eof),    0);
        checkOutput({tag, "_frame_done"}, 32'(frame_done), 0);
    endtask

    // Expected beat b of the raster: data=b, x=b%XC, y=b/XC.
    task automatic checkBeat(input int b);
        checkOutput($sformatf("beat%0d_data", b), 32'(pix_data), b);
        checkOutput($sformatf("beat%0d_x", b),    32'(pix_x),    b % XC);
        checkOutput($sformatf("beat%0d_y", b),    32'(pix_y),    b / XC);
        checkOutput($sformatf("beat%0d_sof", b),  32'(pix_sof),  (b == 0) ? 1 : 0);
        checkOutput($sformatf("beat%0d_eol", b),  32'(pix_eol),  (b % XC == XC - 1) ? 1 : 0);
        checkOutput($sformatf("beat%0d_eof", b),  32'(pix_eof),  (b == FRAME - 1) ? 1 : 0);
    endtask

    // Called at a negedge; leaves with beat 0 presented.
    task automatic startFrame();
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        #1;
        checkOutput("t0_busy",    32'(busy),      1);
        checkOutput("t0_rd_en",   32'(rd_en),     1);
        checkOutput("t0_rd_addr", 32'(rd_addr),   0);
        checkOutput("t0_valid",   32'(pix_valid), 0);
        @(negedge clk);
        #1;
        checkOutput("t1_valid",   32'(pix_valid), 0);
        checkOutput("t1_rd_addr", 32'(rd_addr),   1);
        @(negedge clk);
        #1;
        checkOutput("t2_valid",   32'(pix_valid), 1);
    endtask

    // mode 0: ready held high; 1: ready low 10 cycles at beat 5; 2: random ready.
    task automatic consumeFrame(input int mode, input int stopAt, input int startAt);
        int   beat      = 0;
        int   cyc       = 0;
        int   stallLeft = 10;
        logic startDone = 1'b0;
        logic r;
        while (beat < stopAt && cyc < 400) begin
            r = 1'b1;
            if (mode == 1 && beat == 5 && stallLeft > 0) begin
                r = 1'b0;
                stallLeft--;
            end else if (mode == 2) begin
                r = 1'($urandom_range(0, 1));
            end
            if (beat == startAt && !startDone) begin
                applyStimulus(1'b1, r);
                startDone = 1'b1;
            end else begin
                applyStimulus(1'b0, r);
            end
            #1;
            if (mode == 0) checkOutput("no_bubble", 32'(pix_valid), 1);
            if (mode == 1 && !r) begin
                checkOutput("stall_rd_addr", 32'(rd_addr), 7);
                checkOutput("stall_rd_en",   32'(rd_en),   0);
            end
            if (pix_valid) checkBeat(beat);
            if (pix_valid && r) beat++;
            @(negedge clk);
            cyc++;
        end
        checkOutput("beat_count", beat, stopAt);
    endtask

    task automatic finishFrame();
        applyStimulus(1'b0, 1'b1);
        #1;
        checkOutput("done_pulse",   32'(frame_done), 1);
        checkOutput("done_busy",    32'(busy),       0);
        checkOutput("done_valid",   32'(pix_valid),  0);
        checkOutput("done_rd_en",   32'(rd_en),      0);
        checkOutput("done_rd_addr", 32'(rd_addr),    FRAME - 1);
        @(negedge clk);
        #1;
        checkOutput("after_done_pulse", 32'(frame_done), 0);
        checkOutput("after_done_busy",  32'(busy),       0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkIdle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] full frame, ready held high");
        startFrame();
        consumeFrame(0, FRAME, -1);
        finishFrame();

        $display("[TB] backpressure at beat 5");
        startFrame();
        consumeFrame(1, FRAME, -1);
        finishFrame();

        $display("[TB] start pulsed while busy");
        startFrame();
        consumeFrame(0, FRAME, 6);
        finishFrame();

        $display("[TB] reset mid-frame then restart");
        startFrame();
        consumeFrame(0, 8, -1);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdle("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        startFrame();
        consumeFrame(0, FRAME, -1);
        finishFrame();

        $display("[TB] random ready");
        startFrame();
        consumeFrame(2, FRAME, -1);
        finishFrame();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
